// File: rtl/clock_display_driver_if.sv
// clock_display_driver_if: time inputs from the clock core and the display-side outputs.
interface clock_display_driver_if;
  logic [5:0] min;
  logic [4:0] hrs;
  logic       AM;
  logic       PM;
  logic       alarm;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       am_led;
  logic       pm_led;
  modport master (output min, hrs, AM, PM, alarm, input seg, dp, an, am_led, pm_led);
  modport slave (input min, hrs, AM, PM, alarm, output seg, dp, an, am_led, pm_led);
endinterface

// File: rtl/clock_display_driver.sv
// clock_display_driver: 4-digit multiplexed 7-seg driver with per-frame time snapshot and alarm blink.
// Defining DISPLAY_LAMP_TEST_EN adds a lamp_test input that lights every segment and LED.
module clock_display_driver #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64,
  parameter bit LZB       = 1'b1
) (
  input  logic clk,
  input  logic rst,
`ifdef DISPLAY_LAMP_TEST_EN
  input  logic lamp_test,
`endif
  clock_display_driver_if.slave bus
);
  logic [15:0] scan_cnt;
  logic [1:0]  digit;
  logic [9:0]  frame_cnt;
  logic        phase;
  logic        fresh;
  logic [5:0]  s_min;
  logic [4:0]  s_hrs;
  logic        s_am;
  logic        s_pm;
  logic        slot_end;
  logic        frame_end;
  logic        blink_end;
  logic        err;
  logic        lz;
  logic        lt;
  logic [5:0]  val;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic [3:0]  bcd;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'h40;
      4'd1: enc = 7'h79;
      4'd2: enc = 7'h24;
      4'd3: enc = 7'h30;
      4'd4: enc = 7'h19;
      4'd5: enc = 7'h12;
      4'd6: enc = 7'h02;
      4'd7: enc = 7'h78;
      4'd8: enc = 7'h00;
      4'd9: enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

`ifdef DISPLAY_LAMP_TEST_EN
  assign lt = lamp_test;
`else
  assign lt = 1'b0;
`endif

  always_comb begin
    slot_end  = scan_cnt == 16'(SCAN_DIV - 1);
    frame_end = slot_end && digit == 2'd3;
    blink_end = frame_cnt == 10'(BLINK_DIV - 1);
    err       = s_min > 6'd59 || s_hrs > 5'd23;
    val       = digit[1] ? {1'b0, s_hrs} : s_min;
    tens      = 4'(val / 6'd10);
    ones      = 4'(val % 6'd10);
    bcd       = digit[0] ? tens : ones;
    lz        = LZB && digit == 2'd3 && tens == 4'd0 && (s_am || s_pm);
    seg_n     = lt ? 7'h00 : err ? 7'h3F : lz ? 7'h7F : enc(bcd);
    // the slot's first cycle is always dark so the previous digit cannot ghost
    an_n      = (scan_cnt == 16'd0 || (bus.alarm && phase && !lt)) ? 4'hF : ~(4'd1 << digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt   <= '0;
      digit      <= '0;
      frame_cnt  <= '0;
      phase      <= 1'b0;
      fresh      <= 1'b1;
      s_min      <= '0;
      s_hrs      <= '0;
      s_am       <= 1'b0;
      s_pm       <= 1'b0;
      bus.seg    <= 7'h7F;
      bus.dp     <= 1'b1;
      bus.an     <= 4'hF;
      bus.am_led <= 1'b0;
      bus.pm_led <= 1'b0;
    end else begin
      scan_cnt <= slot_end ? '0 : scan_cnt + 16'd1;
      if (slot_end) digit <= digit + 2'd1;
      if (frame_end) begin
        frame_cnt <= blink_end ? '0 : frame_cnt + 10'd1;
        if (blink_end) phase <= ~phase;
      end
      fresh <= 1'b0;
      // time is only sampled at frame boundaries so one frame never mixes two readings
      if (frame_end || fresh) begin
        s_min <= bus.min;
        s_hrs <= bus.hrs;
        s_am  <= bus.AM;
        s_pm  <= bus.PM;
      end
      bus.seg    <= seg_n;
      bus.dp     <= ~(lt || (digit == 2'd2 && !phase));
      bus.an     <= an_n;
      bus.am_led <= lt || (s_am && !err);
      bus.pm_led <= lt || (s_pm && !err);
    end
  end
endmodule

// File: tb/tb_clock_display_driver.sv
// tb_clock_display_driver: directed frame-by-frame checks of scan order, decode, snapshot, range error, LZB and blink.
module tb_clock_display_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int n = -1;
  always #5 clk = ~clk;
  clock_display_driver_if bus ();
`ifdef DISPLAY_LAMP_TEST_EN
  logic lamp_test = 1'b0;
`endif
  clock_display_driver #(.SCAN_DIV(4), .BLINK_DIV(2), .LZB(1'b1)) dut (
    .clk(clk),
    .rst(rst),
`ifdef DISPLAY_LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .bus(bus)
  );

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s n=%0d got={seg,dp,an,am,pm}=%h want=%h", tag, n, got, want);
    end
  endtask

  task automatic rst_chk();
    @(negedge clk);
    check("reset", {bus.seg, bus.dp, bus.an, bus.am_led, bus.pm_led}, {7'h7F, 1'b1, 4'hF, 2'b00});
  endtask

  task automatic run(input string tag, input int cnt, input logic [6:0] s0, input logic [6:0] s1,
                     input logic [6:0] s2, input logic [6:0] s3, input logic dpon, input logic am,
                     input logic pm, input logic blank);
    for (int i = 0; i < cnt; i++) begin
      int pos;
      int d;
      logic [3:0] want_an;
      logic [6:0] s;
      @(negedge clk);
      n++;
      pos = n % 16;
      d = pos / 4;
      want_an = (blank || pos % 4 == 0) ? 4'hF : ~(4'd1 << d);
      s = d == 0 ? s0 : d == 1 ? s1 : d == 2 ? s2 : s3;
      if (n == 0) check({tag, "/an"}, {10'd0, bus.an}, {10'd0, want_an});
      else check(tag, {bus.seg, bus.dp, bus.an, bus.am_led, bus.pm_led},
                 {s, !(dpon && d == 2), want_an, am, pm});
    end
  endtask

  initial begin
    bus.min = 6'd34;
    bus.hrs = 5'd12;
    bus.AM = 1'b1;
    bus.PM = 1'b0;
    bus.alarm = 1'b0;
    rst_chk();
    rst_chk();
    rst_chk();
    rst = 1'b0;
    run("f0_decode", 16, 7'h19, 7'h30, 7'h24, 7'h79, 1, 1, 0, 0);
    run("f1_tear", 6, 7'h19, 7'h30, 7'h24, 7'h79, 1, 1, 0, 0);
    bus.min = 6'd35;
    run("f1_tear", 10, 7'h19, 7'h30, 7'h24, 7'h79, 1, 1, 0, 0);
    run("f2_new", 6, 7'h12, 7'h30, 7'h24, 7'h79, 0, 1, 0, 0);
    bus.min = 6'd61;
    bus.hrs = 5'd5;
    run("f2_new", 10, 7'h12, 7'h30, 7'h24, 7'h79, 0, 1, 0, 0);
    run("f3_range", 6, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 0, 0, 0, 0);
    bus.min = 6'd0;
    run("f3_range", 10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 0, 0, 0, 0);
    run("f4_restore", 6, 7'h40, 7'h40, 7'h12, 7'h7F, 1, 1, 0, 0);
    bus.min = 6'd35;
    bus.hrs = 5'd9;
    bus.AM = 1'b0;
    bus.PM = 1'b1;
    run("f4_restore", 10, 7'h40, 7'h40, 7'h12, 7'h7F, 1, 1, 0, 0);
    run("f5_lzb_pm", 6, 7'h12, 7'h30, 7'h10, 7'h7F, 1, 0, 1, 0);
    bus.PM = 1'b0;
    run("f5_lzb_pm", 10, 7'h12, 7'h30, 7'h10, 7'h7F, 1, 0, 1, 0);
    run("f6_24h", 16, 7'h12, 7'h30, 7'h10, 7'h40, 0, 0, 0, 0);
    run("f7_24h", 16, 7'h12, 7'h30, 7'h10, 7'h40, 0, 0, 0, 0);
    bus.alarm = 1'b1;
    run("f8_alarm_on", 16, 7'h12, 7'h30, 7'h10, 7'h40, 1, 0, 0, 0);
    run("f9_alarm_on", 16, 7'h12, 7'h30, 7'h10, 7'h40, 1, 0, 0, 0);
    run("f10_alarm_blank", 16, 7'h12, 7'h30, 7'h10, 7'h40, 0, 0, 0, 1);
    run("f11_alarm_blank", 16, 7'h12, 7'h30, 7'h10, 7'h40, 0, 0, 0, 1);
    run("f12_alarm_on", 16, 7'h12, 7'h30, 7'h10, 7'h40, 1, 0, 0, 0);
    run("f13_alarm_on", 16, 7'h12, 7'h30, 7'h10, 7'h40, 1, 0, 0, 0);
    run("f14_alarm_blank", 6, 7'h12, 7'h30, 7'h10, 7'h40, 0, 0, 0, 1);
    bus.alarm = 1'b0;
    run("f14_alarm_drop", 10, 7'h12, 7'h30, 7'h10, 7'h40, 0, 0, 0, 0);
    run("f15_normal", 16, 7'h12, 7'h30, 7'h10, 7'h40, 0, 0, 0, 0);
    run("f16_normal", 5, 7'h12, 7'h30, 7'h10, 7'h40, 1, 0, 0, 0);
    rst = 1'b1;
    rst_chk();
    rst_chk();
    rst = 1'b0;
    n = -1;
    run("post_rst", 16, 7'h12, 7'h30, 7'h10, 7'h40, 1, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
